uart_tx: RTL and testbench

Serial UART transmitter, the transmit-side counterpart of the UART receiver in the UART test environment. Accepts a parallel word on a single-cycle valid strobe. Emits one frame on `s_data_out` at one bit per `tx_clk` cycle: start bit, data LSB-first, optional even/odd parity bit, stop bit. The `uart_rx` DUT consumes this frame, so `tx_clk` is the bit clock and the receiver oversamples it by prescale.

---
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter.
// A parallel word accepted on a single-cycle strobe is sent LSB-first as one frame:
// start bit, data bits, optional even/odd parity bit, stop bit.
// One bit is sent per tx_clk cycle.
// Both outputs come straight from flops.
// Each output flop is loaded with the value for the state being entered,
// so the line changes on the same edge as the state.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  tx_clk,
  input  logic                  res,
  input  logic [DATA_WIDTH-1:0] p_data_in,
  input  logic                  data_valid_in,
  input  logic                  par_en_in,
  input  logic                  par_typ_in,
  output logic                  s_data_out,
  output logic                  busy_out
);

  // The bit counter needs at least one bit, even when DATA_WIDTH is 1.
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           cnt_inc;
  logic [DATA_WIDTH-1:0]   shadow_q, shadow_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    s_data_q, s_data_d;
  logic                    busy_q, busy_d;

  assign cnt_inc    = cnt_q + 1'b1;
  assign s_data_out = s_data_q;
  assign busy_out   = busy_q;

  // State, counter, shadow copies and output flops.
  // Reset abandons any partial frame at once.
  always_ff @(posedge tx_clk or posedge res) begin
    if (res) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      s_data_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      s_data_q  <= s_data_d;
      busy_q    <= busy_d;
    end
  end

  // Next state plus the line level and busy flag for the state being entered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    s_data_d  = 1'b1;
    busy_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // Requests are only sampled here, so strobes that arrive mid-frame are dropped.
        if (data_valid_in) begin
          shadow_d  = p_data_in;
          par_en_d  = par_en_in;
          par_typ_d = par_typ_in;
          state_d   = START;
          s_data_d  = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        state_d  = DATA;
        cnt_d    = '0;
        s_data_d = shadow_q[0];
      end
      DATA: begin
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          cnt_d = '0;
          if (par_en_q) begin
            state_d  = PARITY;
            s_data_d = (^shadow_q) ^ par_typ_q;
          end else begin
            state_d  = STOP;
            s_data_d = 1'b1;
          end
        end else begin
          cnt_d    = cnt_inc;
          s_data_d = shadow_q[cnt_inc];
        end
      end
      PARITY: begin
        state_d  = STOP;
        s_data_d = 1'b1;
      end
      STOP: begin
        // Returning to IDLE guarantees at least one idle cycle between frames.
        state_d  = IDLE;
        s_data_d = 1'b1;
        busy_d   = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        s_data_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// The bench uses table vectors, directed corner sequences and random frames.
// Every random frame is checked against a frame model built from the word.
module tb_uart_tx;

  localparam int DW = 8;

  logic          tx_clk = 1'b0;
  logic          res;
  logic [DW-1:0] p_data_in;
  logic          data_valid_in;
  logic          par_en_in;
  logic          par_typ_in;
  logic          s_data_out;
  logic          busy_out;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx #(.DATA_WIDTH(DW)) dut (
    .tx_clk        (tx_clk),
    .res           (res),
    .p_data_in     (p_data_in),
    .data_valid_in (data_valid_in),
    .par_en_in     (par_en_in),
    .par_typ_in    (par_typ_in),
    .s_data_out    (s_data_out),
    .busy_out      (busy_out)
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct {
    string         name;
    logic [DW-1:0] data;
    logic          pen;
    logic          ptyp;
    logic [31:0]   exp_bits;  // bit i = line level in frame cycle i
    int            len;
    bit            scramble;  // disturb the inputs while the frame is sent
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, parity chosen so that the
  // total count of ones meets the requested sense, then stop 1.
  function automatic logic [31:0] model_frame(input logic [DW-1:0] d, input logic pen,
                                              input logic ptyp, output int len);
    logic [31:0] f;
    int ones;
    int pos;
    f = '0;
    ones = 0;
    pos = 0;
    f[pos] = 1'b0;
    pos++;
    for (int k = 0; k < DW; k++) begin
      f[pos] = d[k];
      ones += int'(d[k]);
      pos++;
    end
    if (pen) begin
      f[pos] = 1'(((ones % 2) + int'(ptyp)) % 2);
      pos++;
    end
    f[pos] = 1'b1;
    pos++;
    len = pos;
    return f;
  endfunction

  // Send one frame.
  // Accept it, check every cycle of the frame, then check the idle cycle that follows.
  task automatic send_frame(input string name, input logic [DW-1:0] d, input logic pen,
                            input logic ptyp, input logic [31:0] exp_bits,
                            input int len, input bit scramble);
    @(negedge tx_clk);
    p_data_in = d;
    par_en_in = pen;
    par_typ_in = ptyp;
    data_valid_in = 1'b1;
    @(posedge tx_clk);
    for (int i = 0; i < len; i++) begin
      @(negedge tx_clk);
      check($sformatf("%s line[%0d]", name, i), s_data_out, exp_bits[i]);
      check($sformatf("%s busy[%0d]", name, i), busy_out, 1'b1);
      if (scramble && i < len - 1) begin
        data_valid_in = 1'($urandom);
        p_data_in = DW'($urandom);
        par_en_in = 1'($urandom);
        par_typ_in = 1'($urandom);
      end else begin
        data_valid_in = 1'b0;
      end
    end
    @(negedge tx_clk);
    check($sformatf("%s idle line", name), s_data_out, 1'b1);
    check($sformatf("%s idle busy", name), busy_out, 1'b0);
    $display("frame %s data=%h par_en=%b par_typ=%b len=%0d", name, d, pen, ptyp, len);
  endtask

  initial begin
    logic [31:0] ef;
    int          el;
    logic [DW-1:0] rd;
    logic rp, rt;

    vecs[0] = '{"a5_nopar", 8'hA5, 1'b0, 1'b0, 32'h0000034A, 10, 1'b0};
    vecs[1] = '{"a5_even",  8'hA5, 1'b1, 1'b0, 32'h0000054A, 11, 1'b0};
    vecs[2] = '{"a5_odd",   8'hA5, 1'b1, 1'b1, 32'h0000074A, 11, 1'b0};
    vecs[3] = '{"a5_scram", 8'hA5, 1'b1, 1'b1, 32'h0000074A, 11, 1'b1};
    vecs[4] = '{"01_odd",   8'h01, 1'b1, 1'b1, 32'h00000402, 11, 1'b0};

    res = 1'b1;
    p_data_in = '0;
    data_valid_in = 1'b0;
    par_en_in = 1'b0;
    par_typ_in = 1'b0;

    // Reset state, then five idle cycles with the line held high.
    @(negedge tx_clk);
    check("reset line", s_data_out, 1'b1);
    check("reset busy", busy_out, 1'b0);
    @(negedge tx_clk);
    res = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge tx_clk);
      check($sformatf("idle%0d line", i), s_data_out, 1'b1);
      check($sformatf("idle%0d busy", i), busy_out, 1'b0);
    end
    $display("reset and idle hold done");

    for (int v = 0; v < 5; v++)
      send_frame(vecs[v].name, vecs[v].data, vecs[v].pen, vecs[v].ptyp,
                 vecs[v].exp_bits, vecs[v].len, vecs[v].scramble);

    // Hold the strobe high continuously with 0xFF.
    // Two frames must appear, separated by exactly one idle cycle.
    // The strobe is driven during the idle cycle left by the previous frame,
    // so the first frame is accepted at the earliest edge allowed.
    p_data_in = 8'hFF;
    par_en_in = 1'b0;
    par_typ_in = 1'b0;
    data_valid_in = 1'b1;
    ef = model_frame(8'hFF, 1'b0, 1'b0, el);
    @(posedge tx_clk);
    for (int i = 0; i < 2 * el + 1; i++) begin
      @(negedge tx_clk);
      if (i == el) begin
        check("b2b gap line", s_data_out, 1'b1);
        check("b2b gap busy", busy_out, 1'b0);
      end else begin
        check($sformatf("b2b line[%0d]", i), s_data_out, ef[(i < el) ? i : i - el - 1]);
        check($sformatf("b2b busy[%0d]", i), busy_out, 1'b1);
      end
      if (i == 2 * el) data_valid_in = 1'b0;
    end
    @(negedge tx_clk);
    check("b2b end line", s_data_out, 1'b1);
    check("b2b end busy", busy_out, 1'b0);
    $display("frame b2b data=ff x2 gap=1");

    // Start a 0x00 frame and reset it during data bit 3.
    @(negedge tx_clk);
    p_data_in = 8'h00;
    par_en_in = 1'b0;
    data_valid_in = 1'b1;
    @(posedge tx_clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge tx_clk);
      data_valid_in = 1'b0;
      check($sformatf("rst00 line[%0d]", i), s_data_out, 1'b0);
      check($sformatf("rst00 busy[%0d]", i), busy_out, 1'b1);
    end
    res = 1'b1;
    #1;
    check("midreset line", s_data_out, 1'b1);
    check("midreset busy", busy_out, 1'b0);
    @(negedge tx_clk);
    check("inreset line", s_data_out, 1'b1);
    check("inreset busy", busy_out, 1'b0);
    res = 1'b0;
    $display("mid-frame reset on data bit 3 of 00");
    ef = model_frame(8'h3C, 1'b0, 1'b0, el);
    send_frame("3c_after_rst", 8'h3C, 1'b0, 1'b0, ef, el, 1'b0);

    // Random frames against the reference model, with the inputs disturbed mid-frame.
    for (int r = 0; r < 20; r++) begin
      rd = DW'($urandom);
      rp = 1'($urandom);
      rt = 1'($urandom);
      ef = model_frame(rd, rp, rt, el);
      send_frame($sformatf("rand%0d", r), rd, rp, rt, ef, el, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
